// File: rtl/axis_serdes_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ AXI-Stream word sources onto one
// byte-wide link FIFO as {header, word bytes LSB first} frames.
module axis_serdes_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LOGIC_SIZE = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic [NUM_REQ*LOGIC_SIZE-1:0] m_axis_tdata,
    input  logic [NUM_REQ-1:0]            m_axis_valid,
    output logic [NUM_REQ-1:0]            m_axis_ready,
    output logic [7:0]                    o_to_fifo,
    output logic                          w_req,
    input  logic                          w_full,
    output logic [3:0]                    grant_id,
    output logic                          busy,
    output logic [CNT_W-1:0]              frame_cnt
);

    localparam int NB   = LOGIC_SIZE / 8;
    localparam int BC_W = $clog2(NB);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [3:0]              grant_id_q, grant_id_d;
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic [LOGIC_SIZE-1:0]   word_q, word_d;

    logic [15:0]             valid_pad;
    logic [4:0]              cand_sum;
    logic [3:0]              cand;
    logic                    win_found;
    logic [3:0]              win_id;
    logic [LOGIC_SIZE-1:0]   sel_word;
    logic [NUM_REQ-1:0]      win_onehot;
    logic [NUM_REQ-1:0]      ready_raw;
    logic                    w_req_raw;
    logic                    busy_raw;
    logic [7:0]              o_byte;
    logic [7:0]              data_byte;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        valid_pad = 16'(m_axis_valid);
        win_found = 1'b0;
        win_id    = 4'd0;
        cand_sum  = 5'd0;
        cand      = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + 5'(k);
            cand     = (cand_sum >= 5'(NUM_REQ)) ? 4'(cand_sum - 5'(NUM_REQ)) : 4'(cand_sum);
            if (!win_found && valid_pad[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end else begin
                win_found = win_found;
            end
        end
    end

    // Winner's word and one-hot ready vector.
    always_comb begin
        sel_word   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == 4'(i)) begin
                sel_word      = m_axis_tdata[i*LOGIC_SIZE +: LOGIC_SIZE];
                win_onehot[i] = 1'b1;
            end else begin
                win_onehot[i] = 1'b0;
            end
        end
        data_byte = 8'(word_q >> {byte_cnt_q, 3'b000});
    end

    // Next-state and frame sequencing.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        grant_id_d  = grant_id_q;
        frame_cnt_d = frame_cnt_q;
        word_d      = word_q;
        ready_raw   = '0;
        w_req_raw   = 1'b0;
        busy_raw    = 1'b0;
        o_byte      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ready_raw  = win_onehot;
                    word_d     = sel_word;
                    grant_id_d = win_id;
                    rr_ptr_d   = (win_id == 4'(NUM_REQ - 1)) ? 4'd0 : win_id + 4'd1;
                    state_d    = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                busy_raw  = 1'b1;
                o_byte    = {4'hA, grant_id_q};
                w_req_raw = !w_full;
                if (!w_full) begin
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                busy_raw  = 1'b1;
                o_byte    = data_byte;
                w_req_raw = !w_full;
                if (!w_full) begin
                    if (byte_cnt_q == BC_LAST) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are held low for the whole reset cycle.
    always_comb begin
        if (axis_reset) begin
            m_axis_ready = '0;
            w_req        = 1'b0;
            busy         = 1'b0;
        end else begin
            m_axis_ready = ready_raw;
            w_req        = w_req_raw;
            busy         = busy_raw;
        end
        o_to_fifo = o_byte;
        grant_id  = grant_id_q;
        frame_cnt = frame_cnt_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 4'd0;
            byte_cnt_q  <= '0;
            grant_id_q  <= 4'd0;
            frame_cnt_q <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            grant_id_q  <= grant_id_d;
            frame_cnt_q <= frame_cnt_d;
            word_q      <= word_d;
        end
    end

endmodule

// File: tb/tb_axis_serdes_arbiter.sv
// Directed bench for axis_serdes_arbiter: reset, mid-frame reset, round-robin
// order, single-source framing, back-pressure stalls and frame counter wrap.
module tb_axis_serdes_arbiter;

    localparam int NR = 4;
    localparam int LS = 32;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*LS-1:0]  tdata;
    logic [NR-1:0]     valid;
    logic [NR-1:0]     ready;
    logic [7:0]        o_byte;
    logic              w_req;
    logic              w_full;
    logic [3:0]        grant_id;
    logic              busy;
    logic [CW-1:0]     frame_cnt;

    int nvec = 0;
    int nmis = 0;
    int writes;

    logic [7:0] t1_bytes [5]  = '{8'hA2, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic       t3_full  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] t3_byte  [10] = '{8'hA1, 8'hA1, 8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    logic       t3_wreq  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    axis_serdes_arbiter #(
        .NUM_REQ   (NR),
        .LOGIC_SIZE(LS),
        .CNT_W     (CW)
    ) dut (
        .axis_aclk   (clk),
        .axis_reset  (rst),
        .m_axis_tdata(tdata),
        .m_axis_valid(valid),
        .m_axis_ready(ready),
        .o_to_fifo   (o_byte),
        .w_req       (w_req),
        .w_full      (w_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample point: falling edge, with per-cycle handshake invariants.
    task automatic smp();
        @(negedge clk);
        chk("ready_onehot0", 32'($onehot0(ready)), 32'd1);
        chk("ready_outside_idle", 32'(busy & (|ready)), 32'd0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int s, input logic [31:0] w);
        tdata[s*LS +: LS] = w;
    endtask

    initial begin
        rst    = 1'b1;
        valid  = '0;
        w_full = 1'b0;
        tdata  = '0;
        adv();
        adv();

        // Reset forces handshakes low even with every source valid.
        valid = 4'hF;
        smp();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wreq", 32'(w_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        adv();
        rst   = 1'b0;
        valid = '0;
        smp();
        chk("init_grant", 32'(grant_id), 32'd0);
        chk("init_frame", 32'(frame_cnt), 32'd0);
        chk("init_byte", 32'(o_byte), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_wreq", 32'(w_req), 32'd0);

        for (int i = 0; i < NR; i++) begin
            set_word(i, 32'h03020100 + 32'h10101010 * i);
        end

        // Mid-frame reset at byte_cnt=2 of a src3 frame.
        adv();
        valid = 4'b1000;
        smp();
        chk("t4_ready3", 32'(ready), 32'h8);
        adv();
        valid = '0;
        smp();
        chk("t4_hdr", 32'(o_byte), 32'hA3);
        chk("t4_grant", 32'(grant_id), 32'd3);
        chk("t4_hdr_wreq", 32'(w_req), 32'd1);
        adv();
        smp();
        chk("t4_b0", 32'(o_byte), 32'h30);
        adv();
        smp();
        chk("t4_b1", 32'(o_byte), 32'h31);
        adv();
        rst = 1'b1;
        smp();
        chk("t4_rst_wreq", 32'(w_req), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        adv();
        rst   = 1'b0;
        valid = 4'b1001;
        smp();
        chk("t4_post_busy", 32'(busy), 32'd0);
        chk("t4_post_wreq", 32'(w_req), 32'd0);
        chk("t4_post_frame", 32'(frame_cnt), 32'd0);
        chk("t4_tie_src0", 32'(ready), 32'h1);
        adv();
        valid = '0;
        smp();
        chk("t4_new_hdr", 32'(o_byte), 32'hA0);
        chk("t4_new_grant", 32'(grant_id), 32'd0);
        for (int k = 0; k < 4; k++) begin
            adv();
            smp();
            chk("t4_new_data", 32'(o_byte), 32'(k));
        end
        adv();
        smp();
        chk("t4_frame1", 32'(frame_cnt), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);

        // Reset pulse in IDLE returns rr_ptr and frame_cnt to zero.
        adv();
        rst = 1'b1;
        smp();
        adv();
        rst = 1'b0;
        smp();
        chk("rst2_frame", 32'(frame_cnt), 32'd0);

        // All sources valid: order 0,1,2,3,0,1 at one accept per 6 cycles.
        adv();
        valid = 4'hF;
        for (int f = 0; f < 6; f++) begin
            smp();
            chk("t2_ready", 32'(ready), 32'(1 << (f % 4)));
            chk("t2_idle_busy", 32'(busy), 32'd0);
            adv();
            if (f == 5) valid = '0;
            smp();
            chk("t2_hdr", 32'(o_byte), 32'(8'hA0 | (f % 4)));
            chk("t2_grant", 32'(grant_id), 32'(f % 4));
            chk("t2_wreq", 32'(w_req), 32'd1);
            for (int k = 0; k < 4; k++) begin
                adv();
                smp();
                chk("t2_data", 32'(o_byte), 32'(((f % 4) << 4) | k));
            end
            adv();
        end
        smp();
        chk("t2_frames", 32'(frame_cnt), 32'd6);
        chk("t2_end_busy", 32'(busy), 32'd0);

        // Single source 2, no back-pressure.
        set_word(2, 32'hDDCCBBAA);
        adv();
        valid = 4'b0100;
        smp();
        chk("t1_ready", 32'(ready), 32'h4);
        chk("t1_busy0", 32'(busy), 32'd0);
        adv();
        valid = '0;
        for (int c = 0; c < 5; c++) begin
            smp();
            chk("t1_byte", 32'(o_byte), 32'(t1_bytes[c]));
            chk("t1_wreq", 32'(w_req), 32'd1);
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_grant", 32'(grant_id), 32'd2);
            adv();
        end
        smp();
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_done_wreq", 32'(w_req), 32'd0);
        chk("t1_done_byte", 32'(o_byte), 32'd0);
        chk("t1_frames", 32'(frame_cnt), 32'd7);

        // Source 1 under w_full stalls in HDR and at byte_cnt=1.
        set_word(1, 32'hDDCCBBAA);
        adv();
        valid = 4'b0010;
        smp();
        chk("t3_ready", 32'(ready), 32'h2);
        adv();
        valid = '0;
        set_word(1, 32'h00000000);
        writes = 0;
        for (int c = 0; c < 10; c++) begin
            w_full = t3_full[c];
            smp();
            chk("t3_byte", 32'(o_byte), 32'(t3_byte[c]));
            chk("t3_wreq", 32'(w_req), 32'(t3_wreq[c]));
            if (w_req) writes++;
            adv();
        end
        w_full = 1'b0;
        smp();
        chk("t3_writes", 32'(writes), 32'd5);
        chk("t3_frames", 32'(frame_cnt), 32'd8);

        // Eight src0 frames take the 4-bit frame counter from 8 through 15 to 0.
        adv();
        valid = 4'b0001;
        for (int f = 0; f < 8; f++) begin
            smp();
            chk("t5_ready", 32'(ready), 32'h1);
            chk("t5_frame", 32'(frame_cnt), 32'((8 + f) % 16));
            adv();
            for (int k = 0; k < 5; k++) begin
                if (f == 7 && k == 0) valid = '0;
                smp();
                chk("t5_byte", 32'(o_byte), (k == 0) ? 32'hA0 : 32'(k - 1));
                adv();
            end
        end
        smp();
        chk("t5_wrap", 32'(frame_cnt), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
